// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the five-stage RISC-V core.
//
// It captures the decoder control bits, operand data, immediate, register
// indices and funct bits, and presents them to EX one cycle later. It also
// contains the load-use hazard detector, which freezes PC and IF/ID through
// stall_o and inserts an all-zero bubble into EX. It handles branch flush and
// downstream hold, and keeps saturating bubble and flush event counters.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   *_i control bits      RegWrite/MemtoReg/MemRead/MemWrite/ALUSrc/Branch
//   ALUOp_i [1:0]         10 R, 00 I/load, 01 S, 11 SB
//   valid_i               ID holds a real instruction
//   rs1/rs2_data_i, imm_i operand data and sign-extended immediate
//   rs1/rs2/rd_addr_i     register indices
//   funct_i [9:0]         {funct7, funct3}
//   flush_i               squash the instruction entering EX
//   hold_i                downstream freeze request
//   *_o                   registered copies of the above, plus valid_o
//   stall_o               combinational freeze request to PC and IF/ID
//   bubble_cnt_o          saturating count of inserted bubbles
//   flush_cnt_o           saturating count of squashed valid instructions
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic             Branch_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [9:0]       funct_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic             Branch_o,
  output logic [1:0]       ALUOp_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic [9:0]       funct_o,
  output logic             valid_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_RegWrite, r_MemtoReg, r_MemRead, r_MemWrite;
  logic             r_ALUSrc, r_Branch, r_valid;
  logic [1:0]       r_ALUOp;
  logic [XLEN-1:0]  r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]       r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [9:0]       r_funct;
  logic [CNT_W-1:0] r_bubble_cnt, r_flush_cnt;

  logic w_rs2_used;
  logic w_hazard;
  logic w_clear;

  // Load-use detection: a valid load in EX writing a nonzero rd that the ID
  // instruction reads. rs2 is only a real source for R/SB types (ALUSrc=0)
  // and stores (rs2 supplies the store data even though ALUSrc=1).
  always_comb begin
    w_rs2_used = ~ALUSrc_i | MemWrite_i;
    w_hazard   = r_valid & r_MemRead & (r_rd_addr != 5'd0) & valid_i &
                 ((r_rd_addr == rs1_addr_i) |
                  (w_rs2_used & (r_rd_addr == rs2_addr_i)));
    // A flush redirects fetch, so the hazard must not freeze it.
    stall_o    = (w_hazard & ~flush_i) | hold_i;
    // Flush beats hold; hold beats a bubble.
    w_clear    = rst_i | flush_i | (~hold_i & w_hazard);
  end

  // Pipeline register: clear on reset/flush/bubble, keep on hold, else load.
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_RegWrite <= 1'b0;
      r_MemtoReg <= 1'b0;
      r_MemRead  <= 1'b0;
      r_MemWrite <= 1'b0;
      r_ALUSrc   <= 1'b0;
      r_Branch   <= 1'b0;
      r_ALUOp    <= 2'b00;
      r_rs1_data <= {XLEN{1'b0}};
      r_rs2_data <= {XLEN{1'b0}};
      r_imm      <= {XLEN{1'b0}};
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_rd_addr  <= 5'd0;
      r_funct    <= 10'd0;
      r_valid    <= 1'b0;
    end else if (!hold_i) begin
      r_RegWrite <= RegWrite_i;
      r_MemtoReg <= MemtoReg_i;
      r_MemRead  <= MemRead_i;
      r_MemWrite <= MemWrite_i;
      r_ALUSrc   <= ALUSrc_i;
      r_Branch   <= Branch_i;
      r_ALUOp    <= ALUOp_i;
      r_rs1_data <= rs1_data_i;
      r_rs2_data <= rs2_data_i;
      r_imm      <= imm_i;
      r_rs1_addr <= rs1_addr_i;
      r_rs2_addr <= rs2_addr_i;
      r_rd_addr  <= rd_addr_i;
      r_funct    <= funct_i;
      r_valid    <= valid_i;
    end
  end

  // Saturating event counters; a bubble counts only when neither a flush
  // nor a hold takes precedence, a flush only when it squashes a real one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
      r_flush_cnt  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      if (valid_i && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end else if (!hold_i && w_hazard) begin
      if (r_bubble_cnt != CNT_MAX) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign RegWrite_o   = r_RegWrite;
  assign MemtoReg_o   = r_MemtoReg;
  assign MemRead_o    = r_MemRead;
  assign MemWrite_o   = r_MemWrite;
  assign ALUSrc_o     = r_ALUSrc;
  assign Branch_o     = r_Branch;
  assign ALUOp_o      = r_ALUOp;
  assign rs1_data_o   = r_rs1_data;
  assign rs2_data_o   = r_rs2_data;
  assign imm_o        = r_imm;
  assign rs1_addr_o   = r_rs1_addr;
  assign rs2_addr_o   = r_rs2_addr;
  assign rd_addr_o    = r_rd_addr;
  assign funct_o      = r_funct;
  assign valid_o      = r_valid;
  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch;
  logic [1:0]  ALUOp;
  logic        valid, flush, hold;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [9:0]  funct;

  // main instance (CNT_W = 16)
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [9:0]  funct_o;
  logic        valid_o, stall_o;
  logic [15:0] bubble_cnt, flush_cnt;

  // narrow-counter instance (CNT_W = 2), same stimulus
  logic        s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_ALUSrc_o, s_Branch_o;
  logic [1:0]  s_ALUOp_o;
  logic [31:0] s_rs1_data_o, s_rs2_data_o, s_imm_o;
  logic [4:0]  s_rs1_addr_o, s_rs2_addr_o, s_rd_addr_o;
  logic [9:0]  s_funct_o;
  logic        s_valid_o, s_stall_o;
  logic [1:0]  s_bubble_cnt, s_flush_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(RegWrite), .MemtoReg_i(MemtoReg), .MemRead_i(MemRead),
    .MemWrite_i(MemWrite), .ALUSrc_i(ALUSrc), .Branch_i(Branch), .ALUOp_i(ALUOp),
    .valid_i(valid), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr), .funct_i(funct),
    .flush_i(flush), .hold_i(hold),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .funct_o(funct_o), .valid_o(valid_o), .stall_o(stall_o),
    .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(RegWrite), .MemtoReg_i(MemtoReg), .MemRead_i(MemRead),
    .MemWrite_i(MemWrite), .ALUSrc_i(ALUSrc), .Branch_i(Branch), .ALUOp_i(ALUOp),
    .valid_i(valid), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr), .funct_i(funct),
    .flush_i(flush), .hold_i(hold),
    .RegWrite_o(s_RegWrite_o), .MemtoReg_o(s_MemtoReg_o), .MemRead_o(s_MemRead_o),
    .MemWrite_o(s_MemWrite_o), .ALUSrc_o(s_ALUSrc_o), .Branch_o(s_Branch_o), .ALUOp_o(s_ALUOp_o),
    .rs1_data_o(s_rs1_data_o), .rs2_data_o(s_rs2_data_o), .imm_o(s_imm_o),
    .rs1_addr_o(s_rs1_addr_o), .rs2_addr_o(s_rs2_addr_o), .rd_addr_o(s_rd_addr_o),
    .funct_o(s_funct_o), .valid_o(s_valid_o), .stall_o(s_stall_o),
    .bubble_cnt_o(s_bubble_cnt), .flush_cnt_o(s_flush_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; MemtoReg = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ALUSrc = 1'b0; Branch = 1'b0; ALUOp = 2'b00; valid = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0; funct = 10'd0;
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    idle();
    valid = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1; MemRead = 1'b1;
    ALUSrc = 1'b1; ALUOp = 2'b00; rs1_addr = 5'd1; rd_addr = rd; imm = 32'd16;
  endtask

  task automatic drive_rtype(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    idle();
    valid = 1'b1; RegWrite = 1'b1; ALUOp = 2'b10;
    rs1_addr = rs1; rs2_addr = rs2; rd_addr = rd;
  endtask

  initial begin
    // ---- reset with arbitrary inputs ----
    idle();
    rst = 1'b1; valid = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; rd_addr = 5'd9;
    rs1_data = 32'hDEADBEEF; rs1_addr = 5'd9;
    tick(); tick();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_regwrite", RegWrite_o, 1'b0);
    chk("rst_memread", MemRead_o, 1'b0);
    chk("rst_rs1_data", rs1_data_o, 32'd0);
    chk("rst_rd", rd_addr_o, 5'd0);
    chk("rst_bubble", bubble_cnt, 16'd0);
    chk("rst_flush", flush_cnt, 16'd0);
    chk("rst_stall", stall_o, 1'b0);

    // ---- pass-through R-type ----
    rst = 1'b0;
    drive_rtype(5'd1, 5'd2, 5'd5);
    rs1_data = 32'h12345678; rs2_data = 32'hCAFEBABE; funct = 10'h20F; Branch = 1'b1;
    #1 chk("pt_stall", stall_o, 1'b0);
    tick();
    chk("pt_valid", valid_o, 1'b1);
    chk("pt_regwrite", RegWrite_o, 1'b1);
    chk("pt_aluop", ALUOp_o, 2'b10);
    chk("pt_rs1_data", rs1_data_o, 32'h12345678);
    chk("pt_rs2_data", rs2_data_o, 32'hCAFEBABE);
    chk("pt_rd", rd_addr_o, 5'd5);
    chk("pt_funct", funct_o, 10'h20F);
    chk("pt_branch", Branch_o, 1'b1);

    // ---- load-use on rs2 ----
    drive_load(5'd7);
    #1 chk("lu_pre_stall", stall_o, 1'b0);
    tick();
    chk("lu_load_memread", MemRead_o, 1'b1);
    drive_rtype(5'd3, 5'd7, 5'd8);
    #1 chk("lu_stall_n", stall_o, 1'b1);
    tick();
    chk("lu_bubble_valid", valid_o, 1'b0);
    chk("lu_bubble_regwrite", RegWrite_o, 1'b0);
    chk("lu_bubble_rd", rd_addr_o, 5'd0);
    chk("lu_bubble_memread", MemRead_o, 1'b0);
    chk("lu_bubble_cnt", bubble_cnt, 16'd1);
    chk("lu_stall_n1", stall_o, 1'b0);
    tick();
    chk("lu_dep_valid", valid_o, 1'b1);
    chk("lu_dep_rd", rd_addr_o, 5'd8);
    chk("lu_dep_cnt", bubble_cnt, 16'd1);

    // ---- no false stall: load to x0 ----
    drive_load(5'd0);
    tick();
    drive_rtype(5'd0, 5'd0, 5'd4);
    #1 chk("x0_stall", stall_o, 1'b0);
    tick();
    chk("x0_valid", valid_o, 1'b1);
    chk("x0_cnt", bubble_cnt, 16'd1);

    // ---- no false stall: I-type using rs2 field as imm bits ----
    drive_load(5'd7);
    tick();
    drive_rtype(5'd3, 5'd7, 5'd9);
    ALUSrc = 1'b1; ALUOp = 2'b00;
    #1 chk("itype_stall", stall_o, 1'b0);
    tick();
    chk("itype_rd", rd_addr_o, 5'd9);
    chk("itype_cnt", bubble_cnt, 16'd1);

    // ---- store data dependency does stall (ALUSrc=1, MemWrite=1) ----
    drive_load(5'd7);
    tick();
    idle();
    valid = 1'b1; MemWrite = 1'b1; ALUSrc = 1'b1; ALUOp = 2'b01;
    rs1_addr = 5'd3; rs2_addr = 5'd7;
    #1 chk("store_stall", stall_o, 1'b1);
    tick();
    chk("store_bubble_cnt", bubble_cnt, 16'd2);
    tick();
    chk("store_memwrite", MemWrite_o, 1'b1);
    chk("store_valid", valid_o, 1'b1);

    // ---- flush beats load-use hazard ----
    drive_load(5'd7);
    tick();
    drive_rtype(5'd7, 5'd2, 5'd6);
    flush = 1'b1;
    #1 chk("fl_stall", stall_o, 1'b0);
    tick();
    chk("fl_valid", valid_o, 1'b0);
    chk("fl_regwrite", RegWrite_o, 1'b0);
    chk("fl_cnt", flush_cnt, 16'd1);
    chk("fl_bubble", bubble_cnt, 16'd2);
    // flush of a non-valid ID slot is not counted
    valid = 1'b0;
    tick();
    chk("fl_inv_cnt", flush_cnt, 16'd1);

    // ---- hold for 3 cycles ----
    drive_rtype(5'd1, 5'd2, 5'd10);
    rs1_data = 32'hA5A5A5A5;
    tick();
    drive_rtype(5'd1, 5'd2, 5'd11);
    rs1_data = 32'h0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", stall_o, 1'b1);
      tick();
      chk("hold_rd", rd_addr_o, 5'd10);
      chk("hold_data", rs1_data_o, 32'hA5A5A5A5);
    end
    // hold with flush: flush clears, stall from hold
    flush = 1'b1;
    #1 chk("hf_stall", stall_o, 1'b1);
    tick();
    chk("hf_valid", valid_o, 1'b0);
    chk("hf_cnt", flush_cnt, 16'd2);

    // ---- hold with hazard: no bubble counted ----
    drive_load(5'd7);
    tick();
    drive_rtype(5'd7, 5'd2, 5'd12);
    hold = 1'b1;
    tick();
    chk("hh_memread", MemRead_o, 1'b1);
    chk("hh_cnt", bubble_cnt, 16'd2);

    // ---- saturation: 5 more bubbles ----
    for (int i = 0; i < 5; i++) begin
      drive_load(5'd7);
      tick();
      drive_rtype(5'd3, 5'd7, 5'd8);
      tick();
    end
    chk("sat_small", s_bubble_cnt, 2'd3);
    chk("sat_big", bubble_cnt, 16'd7);
    chk("sat_small_flush", s_flush_cnt, 2'd2);

    // ---- reset mid-stall ----
    drive_load(5'd7);
    tick();
    drive_rtype(5'd7, 5'd2, 5'd8);
    #1 chk("rs_stall_pre", stall_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rs_stall_post", stall_o, 1'b0);
    chk("rs_valid", valid_o, 1'b0);
    chk("rs_bubble", bubble_cnt, 16'd0);
    chk("rs_flush", flush_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage RISC-V core. It sits directly downstream of the main decoder in ID. It captures the decoder's control bits together with the operand data, immediate, register addresses and funct bits, and presents them to EX one cycle later. It contains the load-use hazard detector, which requests an upstream freeze and inserts a bubble. It also handles branch flush and downstream hold, and keeps saturating counters for bubbles and flushes.

## Interface
Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the bubble and flush counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  in  1 each  decoder control bits.
- ALUOp_i  in  2  decoder ALU class: 10 R, 00 I/load, 01 S, 11 SB.
- valid_i  in  1  ID holds a real instruction.
- rs1_data_i, rs2_data_i, imm_i  in  XLEN each  register-file read data and sign-extended immediate.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register indices.
- funct_i  in  10  {funct7, funct3}.
- flush_i  in  1  branch taken in EX; squash the instruction entering EX.
- hold_i  in  1  downstream freeze request.
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, ALUOp_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o  out  same widths as inputs  registered copies.
- valid_o  out  1  EX holds a real instruction.
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt_o, flush_cnt_o  out  CNT_W each  saturating event counters.

## Operation
Hazard detection (combinational, from current register state and ID inputs):
- Condition: valid_o & MemRead_o & (rd_addr_o != 0) & valid_i.
- rs1 match: rd_addr_o == rs1_addr_i. This is always checked.
- rs2 match: rd_addr_o == rs2_addr_i. This is checked only when ALUSrc_i == 0 or MemWrite_i == 1.
- hazard = condition & (rs1 match | rs2 match).
- stall_o = (hazard & ~flush_i) | hold_i.

Register update priority at each edge, highest first:
1. rst_i: every output field and valid_o are cleared to 0. Both counters are cleared to 0.
2. flush_i: every field and valid_o are cleared to 0. flush_cnt_o increments only if the squashed ID instruction had valid_i = 1.
3. hold_i: all fields keep their values. No counter changes.
4. hazard: a bubble is inserted. Every field and valid_o are cleared to 0, and bubble_cnt_o increments. The ID instruction is retained upstream by stall_o.
5. Otherwise: all fields load from the _i ports, and valid_o <= valid_i.

Additional rules:
- A cleared entry is all zero. RegWrite_o = 0 and MemWrite_o = 0 make it architecturally inert.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Branch_i passes through unchanged. Branch resolution is in EX, and this block does not interpret it.
- Inputs with valid_i = 0 are still captured on a normal load. Consumers must qualify every field with valid_o.

## Timing
- Latency: exactly 1 cycle from the _i ports to the _o ports on a normal load.
- stall_o has no register. It is valid in the same cycle as the ID inputs and must settle before the edge.
- Load-use: the load sits in EX in cycle N, and the dependent instruction is in ID. stall_o = 1 in N, and a bubble is in EX in N+1. In N+1 the load has left EX, so stall_o = 0, and the dependent instruction enters EX in N+2.
- flush_i and hazard in the same cycle: the flush wins. stall_o stays 0 from the hazard term so the fetch redirect proceeds, and bubble_cnt_o does not increment.
- hold_i and hazard in the same cycle: the register holds and no bubble is counted. The hazard is re-evaluated next cycle.
- hold_i and flush_i in the same cycle: the flush wins, and stall_o = 1 because of hold_i.
- Reset asserted mid-stall: the state clears at that edge. In the next cycle valid_o = 0, so no hazard is possible.
- Reset values: all outputs 0, and stall_o is 0 when hold_i = 0.

## Test plan
- Reset: assert rst_i for 2 cycles with arbitrary inputs -> all _o, valid_o and counters are 0, and stall_o = 0.
- Pass-through: valid_i = 1, R-type controls (RegWrite_i = 1, ALUOp_i = 10), rs1_data_i = 0x12345678, rd_addr_i = 5 -> these appear on the outputs next cycle with valid_o = 1.
- Load-use: load writes x7 (MemRead_o = 1, rd_addr_o = 7). Next ID is an R-type with rs2_addr_i = 7, ALUSrc_i = 0 -> stall_o = 1 for one cycle, one all-zero bubble, bubble_cnt_o = 1, then the dependent instruction loads.
- No false stall: load to x0, or I-type with rs2_addr_i = 7 and ALUSrc_i = 1, MemWrite_i = 0 -> stall_o = 0 and bubble_cnt_o is unchanged.
- Flush priority: flush_i = 1 coincident with a load-use hazard and valid_i = 1 -> entry cleared, stall_o = 0, flush_cnt_o += 1, bubble_cnt_o unchanged.
- Hold and saturation: hold_i = 1 for 3 cycles -> outputs frozen and stall_o = 1. With CNT_W = 2, force 5 bubbles -> bubble_cnt_o stops at 3.
